quadrilatero_wport_arbiter: RTL and testbench
=============================================

Name: quadrilatero_wport_arbiter

Overview:
Shares the single matrix-register-file write port between N_REQ row-streaming producers, such as the permutation/zero unit, the load unit and the systolic-array writeback. Each producer streams N_ROWS rows of one register and marks the final row with wlast. The arbiter grants the port to one producer for a whole register burst, using round-robin selection between bursts. It forwards the register-file backpressure to the granted producer and flags protocol violations.

Parameters:
N_REQ, 3, number of write requesters (>=2)
RLEN, 128, row width in bits
N_REGS, 8, number of matrix registers
N_ROWS, 4, rows per register (>=2)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  reset, synchronous, active-low
req_waddr_i  in  N_REQ*$clog2(N_REGS)  per-requester destination register, requester k at slice k
req_wrowaddr_i  in  N_REQ*$clog2(N_ROWS)  per-requester row address
req_wdata_i  in  N_REQ*RLEN  per-requester row data
req_we_i  in  N_REQ  per-requester write valid
req_wlast_i  in  N_REQ  per-requester last row of burst
req_wready_o  out  N_REQ  per-requester accept; beat transfers when we & wready
waddr_o  out  $clog2(N_REGS)  register-file write register
wrowaddr_o  out  $clog2(N_ROWS)  register-file write row
wdata_o  out  RLEN  register-file write data
we_o  out  1  register-file write enable
rf_ready_i  in  1  register-file port can accept a write this cycle
gnt_o  out  N_REQ  one-hot current grant, zero when nothing is granted
busy_o  out  1  a burst is in progress (LOCKED state)
err_o  out  1  one-cycle registered pulse on a burst-length violation

Behaviour:
- Beat accepted = we_o & rf_ready_i.
- State machine states: IDLE, LOCKED. Registers: state_q, owner_q, rr_ptr_q, row_cnt_q, err_q.
- Reset (rst_ni low at a clock edge): state=IDLE, owner_q=0, rr_ptr_q=0, row_cnt_q=0, err_q=0.
- While rst_ni is low, the outputs are forced as follows: we_o=0, req_wready_o=0, gnt_o=0, busy_o=0, err_o=0.
- Reset mid-burst abandons the burst. No partial state survives.
- IDLE winner selection:
  - The winner is the first k with req_we_i[k]=1, scanning k=rr_ptr_q, rr_ptr_q+1, ... modulo N_REQ.
  - Grant has zero latency: the winner's fields are muxed to the outputs in the same cycle and gnt_o[winner]=1.
  - req_wready_o[winner]=rf_ready_i. All other req_wready_o bits are 0.
  - If no requester asserts we: gnt_o=0, we_o=0, and the data outputs are don't-care (drive 0).
- IDLE transitions on an accepted beat:
  - wlast=0: go to LOCKED, owner_q=winner, row_cnt_q=1.
  - wlast=1: stay IDLE, rr_ptr_q=(winner+1) mod N_REQ.
  - In both cases, if the beat violates the burst-length rule below, err_q=1 on the next cycle.
- IDLE with no accepted beat (rf_ready_i=0): no state change. The grant may move to a different winner in the next cycle, because it is not locked until the first beat is accepted.
- LOCKED:
  - Only owner_q is muxed. gnt_o=onehot(owner_q). req_wready_o[owner_q]=rf_ready_i. All other wready bits are 0, even if the other requesters assert we.
  - If the owner drops we: we_o=0 and the lock is held (bubble).
  - On an accepted beat with wlast=0: row_cnt_q+1.
  - On an accepted beat with wlast=1: go to IDLE, rr_ptr_q=(owner_q+1) mod N_REQ, row_cnt_q=0.
- Burst-length rule:
  - wlast on the beat with row_cnt_q != N_ROWS-1 is an error.
  - An accepted beat with row_cnt_q == N_ROWS-1 and wlast=0 is an error.
  - On an error, err_q=1 for exactly one cycle. The burst still terminates only on wlast, and row_cnt_q saturates at N_ROWS-1.
- Throughput: one beat per cycle. An IDLE-to-IDLE hand-off on wlast costs no dead cycle, because the next winner is granted in the following cycle.
- Widths: rr_ptr_q and owner_q are $clog2(N_REQ) bits. The modulo wrap is explicit, because N_REQ need not be a power of two.

Decomposition:
- quadrilatero_pkg (shared package) holds the struct typedef wport_req_t {waddr, wrowaddr, wdata, we, wlast}, parameterised by the localparams for the register and row address widths, plus a localparam for the register-file write-port beat width.
- Sub-module quadrilatero_rr_picker (combinational): inputs req[N_REQ] and ptr; outputs valid and idx. This sub-module is reused by other arbiters.

Test Plan:
All scenarios use N_REQ=3, N_ROWS=4 and rf_ready_i=1 unless stated otherwise.
- Single requester: req1 sends 4 beats to reg 5, rows 0..3 -> we_o is high for 4 cycles, waddr_o=5, wrowaddr_o=0,1,2,3, gnt_o=3'b010, busy_o=1 from beat 1 to beat 3, and after the burst rr_ptr_q=2.
- Simultaneous requests: req0 and req2 both request from reset -> req0 is served first (4 beats), req2 is granted on the next cycle, and a following re-request by req0 waits behind req2.
- Lock held across a bubble: req0 starts a burst, drops we for 2 cycles mid-burst, while req1 requests -> req_wready_o[1]=0 throughout, req0 completes, then req1 is granted.
- Backpressure: rf_ready_i is 0 for 3 cycles in the middle of req2's burst -> rows are neither repeated nor skipped, and the total accepted beats equal 4.
- Length errors: req1 asserts wlast on row 1 -> err_o pulses once and the arbiter returns to IDLE. Separately, a 5-beat burst -> err_o pulses on beat 4.
- Reset mid-burst: rst_ni is held low for 1 cycle during beat 2 of req0 -> the outputs are 0 in that cycle, and after release req1 is granted first if it is requesting (rr_ptr_q=0 scan: req0 first if req0 is also requesting).

Source files
------------

// File: rtl/quadrilatero_pkg.sv
// Shared types for the matrix register-file write path: per-producer write beat and arbiter states.
// Widths follow the default register-file geometry (8 registers x 4 rows x 128 bits).
package quadrilatero_pkg;

    localparam int unsigned QD_RLEN         = 128;
    localparam int unsigned QD_N_REGS       = 8;
    localparam int unsigned QD_N_ROWS       = 4;
    localparam int unsigned QD_REG_AW       = $clog2(QD_N_REGS);
    localparam int unsigned QD_ROW_AW       = $clog2(QD_N_ROWS);
    localparam int unsigned QD_WPORT_BEAT_W = QD_REG_AW + QD_ROW_AW + QD_RLEN;

    typedef struct packed {
        logic [QD_REG_AW-1:0] waddr;
        logic [QD_ROW_AW-1:0] wrowaddr;
        logic [QD_RLEN-1:0]   wdata;
        logic                 we;
        logic                 wlast;
    } wport_req_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/quadrilatero_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning upward from ptr_i, wrapping modulo N_REQ.
// Zero latency; valid_o low when no request is asserted.
module quadrilatero_rr_picker #(
    parameter  int unsigned N_REQ = 3,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin : pick
        int unsigned cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(ptr_i) + i) % N_REQ;
            if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/quadrilatero_wport_arbiter.sv
// Shares the register-file write port between N_REQ row-streaming producers, one whole burst per grant,
// round-robin between bursts; zero-latency grant, rf_ready_i forwarded to the owner only.
module quadrilatero_wport_arbiter
    import quadrilatero_pkg::*;
#(
    parameter  int unsigned N_REQ  = 3,
    parameter  int unsigned RLEN   = QD_RLEN,
    parameter  int unsigned N_REGS = QD_N_REGS,
    parameter  int unsigned N_ROWS = QD_N_ROWS,
    localparam int unsigned REG_AW = $clog2(N_REGS),
    localparam int unsigned ROW_AW = $clog2(N_ROWS),
    localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ*REG_AW-1:0]  req_waddr_i,
    input  logic [N_REQ*ROW_AW-1:0]  req_wrowaddr_i,
    input  logic [N_REQ*RLEN-1:0]    req_wdata_i,
    input  logic [N_REQ-1:0]         req_we_i,
    input  logic [N_REQ-1:0]         req_wlast_i,
    output logic [N_REQ-1:0]         req_wready_o,
    output logic [REG_AW-1:0]        waddr_o,
    output logic [ROW_AW-1:0]        wrowaddr_o,
    output logic [RLEN-1:0]          wdata_o,
    output logic                     we_o,
    input  logic                     rf_ready_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(N_ROWS - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ROW_AW-1:0] row_cnt_q, row_cnt_d;
    logic              err_q, err_d;

    wport_req_t        req_s [N_REQ];
    wport_req_t        sel_req;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic              sel_vld;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  next_ptr;
    logic              accept;
    logic              bad_len;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_s[g].waddr    = req_waddr_i[g*REG_AW +: REG_AW];
        assign req_s[g].wrowaddr = req_wrowaddr_i[g*ROW_AW +: ROW_AW];
        assign req_s[g].wdata    = req_wdata_i[g*RLEN +: RLEN];
        assign req_s[g].we       = req_we_i[g];
        assign req_s[g].wlast    = req_wlast_i[g];
    end

    quadrilatero_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i   (req_we_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_comb begin
        sel_idx      = owner_q;
        sel_vld      = 1'b1;
        if (state_q == ARB_IDLE) begin
            sel_idx = pick_idx;
            sel_vld = pick_vld;
        end
        sel_req      = req_s[sel_idx];

        gnt_o        = '0;
        req_wready_o = '0;
        we_o         = 1'b0;
        waddr_o      = '0;
        wrowaddr_o   = '0;
        wdata_o      = '0;
        // All handshake outputs are squashed while reset is asserted.
        if (rst_ni && sel_vld) begin
            gnt_o[sel_idx]        = 1'b1;
            req_wready_o[sel_idx] = rf_ready_i;
            we_o                  = sel_req.we;
            if (sel_req.we) begin
                waddr_o    = sel_req.waddr;
                wrowaddr_o = sel_req.wrowaddr;
                wdata_o    = sel_req.wdata;
            end
        end
        busy_o   = rst_ni && (state_q == ARB_LOCKED);
        err_o    = rst_ni && err_q;

        accept   = we_o && rf_ready_i;
        bad_len  = sel_req.wlast ? (row_cnt_q != LAST_ROW) : (row_cnt_q == LAST_ROW);
        next_ptr = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        row_cnt_d = row_cnt_q;
        err_d     = 1'b0;
        if (accept) begin
            err_d = bad_len;
            if (sel_req.wlast) begin
                state_d   = ARB_IDLE;
                rr_ptr_d  = next_ptr;
                row_cnt_d = '0;
            end else begin
                // Over-long bursts stay locked until wlast; the counter pins at the last row.
                state_d = ARB_LOCKED;
                owner_d = sel_idx;
                if (row_cnt_q != LAST_ROW) begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            row_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            row_cnt_q <= row_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_quadrilatero_wport_arbiter.sv
// Directed bench for the write-port arbiter: queue-driven producers, a burst-level reference model
// checked every cycle, and literal expectations on the logged transfer sequence.
module tb_quadrilatero_wport_arbiter;

    localparam int NR = 3;
    localparam int RL = 128;
    localparam int AW = 3;
    localparam int WW = 2;
    localparam int NROWS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              rf_ready;
    logic [AW-1:0]     in_a [NR];
    logic [WW-1:0]     in_r [NR];
    logic [RL-1:0]     in_d [NR];
    logic [NR-1:0]     in_we;
    logic [NR-1:0]     in_last;

    logic [NR*AW-1:0]  waddr_v;
    logic [NR*WW-1:0]  wrow_v;
    logic [NR*RL-1:0]  wdata_v;

    logic [NR-1:0]     wready;
    logic [NR-1:0]     gnt;
    logic [AW-1:0]     waddr;
    logic [WW-1:0]     wrow;
    logic [RL-1:0]     wdata;
    logic              we;
    logic              busy;
    logic              err;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign waddr_v[g*AW +: AW] = in_a[g];
        assign wrow_v[g*WW +: WW]  = in_r[g];
        assign wdata_v[g*RL +: RL] = in_d[g];
    end

    quadrilatero_wport_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_waddr_i    (waddr_v),
        .req_wrowaddr_i (wrow_v),
        .req_wdata_i    (wdata_v),
        .req_we_i       (in_we),
        .req_wlast_i    (in_last),
        .req_wready_o   (wready),
        .waddr_o        (waddr),
        .wrowaddr_o     (wrow),
        .wdata_o        (wdata),
        .we_o           (we),
        .rf_ready_i     (rf_ready),
        .gnt_o          (gnt),
        .busy_o         (busy),
        .err_o          (err)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] r;
        logic          l;
        logic [RL-1:0] d;
    } beat_t;

    beat_t q [NR][$];
    bit    hold [NR];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int   lg_cyc [$];
    int   lg_k [$];
    int   lg_a [$];
    int   lg_r [$];
    logic lg_busy [$];
    int   err_cycles [$];
    logic s_we;
    logic [NR-1:0] s_gnt, s_rdy;

    // Burst-level reference: who holds the port, where the next scan starts, beats so far in the burst.
    bit m_locked, m_err;
    int m_owner, m_ptr, m_beats;

    task automatic chk(input string nm, input logic [RL-1:0] act, input logic [RL-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (q[k].size() > 0 && !hold[k]) begin
                in_we[k] = 1'b1; in_a[k] = q[k][0].a; in_r[k] = q[k][0].r;
                in_d[k] = q[k][0].d; in_last[k] = q[k][0].l;
            end else begin
                in_we[k] = 1'b0; in_a[k] = '0; in_r[k] = '0; in_d[k] = '0; in_last[k] = 1'b0;
            end
        end
    endtask

    task automatic push_burst(input int k, input int addr, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.a = AW'(addr);
            b.r = WW'(i % NROWS);
            b.l = (i == last_at);
            b.d = {$urandom, $urandom, $urandom, $urandom};
            q[k].push_back(b);
        end
        drive();
    endtask

    task automatic clear_logs();
        lg_cyc.delete(); lg_k.delete(); lg_a.delete(); lg_r.delete(); lg_busy.delete();
        err_cycles.delete();
    endtask

    task automatic step();
        int sel, kk, ak;
        logic [NR-1:0] e_gnt, e_rdy, acc_v;
        logic e_we;
        @(negedge clk);
        sel = -1;
        if (m_locked) sel = m_owner;
        else begin
            for (int i = 0; i < NR; i++) begin
                kk = (m_ptr + i) % NR;
                if (sel < 0 && in_we[kk]) sel = kk;
            end
        end
        e_gnt = '0; e_rdy = '0; e_we = 1'b0;
        if (rst_n && sel >= 0) begin
            e_gnt[sel] = 1'b1;
            e_rdy[sel] = rf_ready;
            e_we = in_we[sel];
        end
        chk("gnt", gnt, e_gnt);
        chk("wready", wready, e_rdy);
        chk("we", we, e_we);
        chk("busy", busy, rst_n && m_locked);
        chk("err", err, rst_n && m_err);
        if (e_we) begin
            chk("waddr", waddr, in_a[sel]);
            chk("wrowaddr", wrow, in_r[sel]);
            chk("wdata", wdata, in_d[sel]);
        end
        s_we = we; s_gnt = gnt; s_rdy = wready;
        if (we && rf_ready) begin
            ak = -1;
            for (int i = 0; i < NR; i++) if (gnt[i]) ak = i;
            lg_cyc.push_back(cyc); lg_k.push_back(ak); lg_a.push_back(int'(waddr));
            lg_r.push_back(int'(wrow)); lg_busy.push_back(busy);
        end
        if (err) err_cycles.push_back(cyc);
        acc_v = in_we & wready;
        @(posedge clk);
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (e_we && rf_ready) begin
                if (in_last[sel]) begin
                    m_err = (m_beats < NROWS - 1);
                    m_locked = 0; m_ptr = (sel + 1) % NR; m_beats = 0;
                end else begin
                    m_err = (m_beats >= NROWS - 1);
                    m_locked = 1; m_owner = sel; m_beats++;
                end
            end
        end
        cyc++;
        #1;
        for (int k = 0; k < NR; k++) if (acc_v[k] && q[k].size() > 0) void'(q[k].pop_front());
        drive();
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_budget", q[0].size() + q[1].size() + q[2].size(), 0);
    endtask

    initial begin
        m_locked = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
        rst_n = 1'b0; rf_ready = 1'b1;
        for (int k = 0; k < NR; k++) hold[k] = 0;
        drive();
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        // Single requester, reg 5 rows 0..3
        clear_logs();
        push_burst(1, 5, 4, 3);
        run_until_empty(20);
        chk("s1_beats", lg_k.size(), 4);
        if (lg_k.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("s1_row%0d", i), lg_r[i], i);
                chk($sformatf("s1_addr%0d", i), lg_a[i], 5);
                chk($sformatf("s1_owner%0d", i), lg_k[i], 1);
                chk($sformatf("s1_busy%0d", i), lg_busy[i], (i > 0));
            end
        end
        // Pointer now at 2: req2 beats req0 when both ask
        clear_logs();
        push_burst(0, 1, 4, 3);
        push_burst(2, 2, 4, 3);
        run_until_empty(30);
        chk("s1_ptr_first", lg_k[0], 2);
        chk("s1_ptr_second", lg_k[4], 0);

        // Simultaneous requests from reset, req0 re-requests behind req2
        rst_n = 1'b0; drive(); step(); rst_n = 1'b1; drive();
        clear_logs();
        push_burst(0, 0, 4, 3);
        push_burst(2, 6, 4, 3);
        push_burst(0, 7, 4, 3);
        run_until_empty(40);
        chk("s2_beats", lg_k.size(), 12);
        chk("s2_first", lg_k[0], 0);
        chk("s2_second", lg_k[4], 2);
        chk("s2_third", lg_k[8], 0);
        chk("s2_handoff1", lg_cyc[4] - lg_cyc[3], 1);
        chk("s2_handoff2", lg_cyc[8] - lg_cyc[7], 1);

        // Lock held across a 2-cycle bubble while req1 waits
        clear_logs();
        push_burst(0, 3, 4, 3);
        step(); step();
        push_burst(1, 4, 4, 3);
        hold[0] = 1; drive();
        step(); step();
        hold[0] = 0; drive();
        run_until_empty(30);
        chk("s3_owner_last", lg_k[3], 0);
        chk("s3_next", lg_k[4], 1);
        chk("s3_bubble", lg_cyc[2] - lg_cyc[1], 3);

        // Backpressure mid-burst on req2
        clear_logs();
        push_burst(2, 1, 4, 3);
        step(); step();
        rf_ready = 1'b0;
        step(); step(); step();
        rf_ready = 1'b1;
        run_until_empty(20);
        chk("s4_beats", lg_k.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("s4_row%0d", i), lg_r[i], i);
        chk("s4_stall", lg_cyc[2] - lg_cyc[1], 4);

        // Early wlast on row 1
        clear_logs();
        push_burst(1, 2, 2, 1);
        run_until_empty(10);
        step(); step();
        chk("s5a_err_count", err_cycles.size(), 1);
        chk("s5a_err_cycle", err_cycles[0], lg_cyc[1] + 1);
        chk("s5a_idle", busy, 0);

        // Five-beat burst
        clear_logs();
        push_burst(0, 3, 5, 4);
        run_until_empty(12);
        step(); step();
        chk("s5b_beats", lg_k.size(), 5);
        chk("s5b_err_count", err_cycles.size(), 1);
        chk("s5b_err_cycle", err_cycles[0], lg_cyc[4]);

        // Reset during beat 2 of req0; req0 abandons its burst
        clear_logs();
        push_burst(0, 5, 4, 3);
        step(); step();
        push_burst(1, 6, 4, 3);
        rst_n = 1'b0;
        q[0].delete();
        drive();
        step();
        chk("s6_rst_we", s_we, 0);
        chk("s6_rst_gnt", s_gnt, 0);
        chk("s6_rst_rdy", s_rdy, 0);
        rst_n = 1'b1; drive();
        run_until_empty(20);
        chk("s6_beats", lg_k.size(), 6);
        chk("s6_after_rst", lg_k[2], 1);
        chk("s6_after_row", lg_r[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
